// File: rtl/rpc_sched_pkg.sv
// ============================================================================
// Module      : rpc_sched_pkg
// Description : Shared types and constants for the RPC command scheduler:
//               split-request encoding, scheduler FSM states, arbitration
//               grant tag and the captured request record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpc_sched_pkg;

    // Bytes per DRAM word; byte addresses are converted to word addresses
    // by dropping the low WordShift bits.
    localparam int WordBytes = 32;
    localparam int WordShift = $clog2(WordBytes);

    // The request record carries a fixed-width address so one type serves
    // every AddrWidth configuration; unused upper bits are zero.
    localparam int ReqAddrWidth = 64;

    typedef enum logic [1:0] {
        SPLIT_NONE   = 2'b00,
        SPLIT_FIRST  = 2'b01,
        SPLIT_SECOND = 2'b10
    } split_req_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_A = 2'd1,
        ISSUE_B = 2'd2
    } sched_state_e;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ReqAddrWidth-1:0] addr;
        logic [5:0]              len;
        logic                    is_write;
    } req_t;

endpackage : rpc_sched_pkg

`default_nettype wire

// File: rtl/rpc_page_split_calc.sv
// ============================================================================
// Module      : rpc_page_split_calc
// Description : Combinational page-crossing calculator. From a captured
//               request it derives whether the burst crosses a DRAM page and
//               the length/address of each resulting command. PageWords is a
//               power of two >= 64, so a 64-word burst splits at most once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpc_page_split_calc
    import rpc_sched_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int PageWords = 64
) (
    input  req_t                 req_i,
    output logic                 split_o,
    output logic [5:0]           first_len_o,
    output logic [AddrWidth-1:0] first_addr_o,
    output logic [5:0]           second_len_o,
    output logic [AddrWidth-1:0] second_addr_o
);

    localparam int OffBits   = $clog2(PageWords);
    localparam int SumBits   = OffBits + 1;
    localparam int PageShift = OffBits + WordShift;

    localparam logic [AddrWidth-1:0] WordMask  = ~((AddrWidth'(1) << WordShift) - AddrWidth'(1));
    localparam logic [AddrWidth-1:0] PageMask  = ~((AddrWidth'(1) << PageShift) - AddrWidth'(1));
    localparam logic [AddrWidth-1:0] PageBytes = AddrWidth'(1) << PageShift;

    logic [AddrWidth-1:0] w_addr;
    logic [OffBits-1:0]   w_off;
    logic [SumBits-1:0]   w_sum;
    logic [SumBits-1:0]   w_room;

    assign w_addr = req_i.addr[AddrWidth-1:0];

    // Word offset inside the page: (addr >> 5) mod PageWords.
    assign w_off = w_addr[PageShift-1:WordShift];

    // One extra bit keeps off + len from wrapping, so the compare is exact.
    assign w_sum   = {1'b0, w_off} + SumBits'(req_i.len);
    assign split_o = (w_sum >= SumBits'(PageWords));

    // Words remaining in the current page (1..PageWords).
    assign w_room = SumBits'(PageWords) - {1'b0, w_off};

    // When split, the first half fills the page and is never longer than len,
    // and the second half is the remainder; both fit in 6 bits.
    assign first_len_o  = split_o ? 6'(w_room - SumBits'(1)) : req_i.len;
    assign second_len_o = 6'(SumBits'(req_i.len) - w_room);

    assign first_addr_o  = w_addr & WordMask;
    // Start of the next page; wraps naturally at the top of the address space.
    assign second_addr_o = (w_addr & PageMask) + PageBytes;

    generate
        if (AddrWidth < ReqAddrWidth) begin : g_addr_hi_unused
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^req_i.addr[ReqAddrWidth-1:AddrWidth];
        end
    endgenerate

    logic w_unused_is_write;
    assign w_unused_is_write = req_i.is_write;

endmodule : rpc_page_split_calc

`default_nettype wire

// File: rtl/rpc_cmd_scheduler.sv
// ============================================================================
// Module      : rpc_cmd_scheduler
// Description : Round-robin arbiter between AXI read and write burst
//               requests. Page-crossing bursts are issued as two commands
//               (split_req 01 then 10). Write commands wait for a buffered
//               write mask, tracked by a credit counter fed by completed W
//               bursts. Optional write-stall performance counter is built
//               when RPC_CMD_SCHED_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpc_cmd_scheduler
    import rpc_sched_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int BufDepth  = 4,
    parameter int PageWords = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [5:0]           ar_len_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [5:0]           aw_len_i,
    input  logic                 w_last_hs_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic                 cmd_is_write_o,
    output logic [1:0]           cmd_split_req_o,
    output logic [5:0]           cmd_len_o,
    output logic [AddrWidth-1:0] cmd_addr_o,
    output logic                 busy_o,
    output logic [31:0]          wr_stall_cnt_o
);

    localparam int                     CreditWidth = $clog2(BufDepth + 2);
    localparam logic [CreditWidth-1:0] CreditMax   = CreditWidth'(BufDepth + 1);

    sched_state_e           state_q, state_d;
    grant_e                 last_grant_q, last_grant_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [5:0]             len_q, len_d;
    logic                   is_write_q, is_write_d;
    logic [CreditWidth-1:0] credit_q, credit_d;

    req_t                   w_req;
    logic                   w_split;
    logic [5:0]             w_first_len;
    logic [AddrWidth-1:0]   w_first_addr;
    logic [5:0]             w_second_len;
    logic [AddrWidth-1:0]   w_second_addr;
    logic                   w_grant_r;
    logic                   w_grant_w;
    logic                   w_credit_take;

    assign w_req.addr     = ReqAddrWidth'(addr_q);
    assign w_req.len      = len_q;
    assign w_req.is_write = is_write_q;

    rpc_page_split_calc #(
        .AddrWidth (AddrWidth),
        .PageWords (PageWords)
    ) u_split_calc (
        .req_i         (w_req),
        .split_o       (w_split),
        .first_len_o   (w_first_len),
        .first_addr_o  (w_first_addr),
        .second_len_o  (w_second_len),
        .second_addr_o (w_second_addr)
    );

    // A lone requester wins; on a tie the side not granted last time wins.
    assign w_grant_r = ar_valid_i && (!aw_valid_i || (last_grant_q == GRANT_WRITE));
    assign w_grant_w = aw_valid_i && (!ar_valid_i || (last_grant_q == GRANT_READ));

    // Only the first (or sole) command of a write consumes a mask credit.
    assign w_credit_take = (state_q == ISSUE_A) && is_write_q && cmd_valid_o && cmd_ready_i;

    assign busy_o = (state_q != IDLE);

    // State, arbitration history and captured request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_WRITE;
            addr_q       <= '0;
            len_q        <= '0;
            is_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            is_write_q   <= is_write_d;
        end
    end

    // Next-state, request capture and command outputs; ready only in IDLE.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        addr_d          = addr_q;
        len_d           = len_q;
        is_write_d      = is_write_q;
        ar_ready_o      = 1'b0;
        aw_ready_o      = 1'b0;
        cmd_valid_o     = 1'b0;
        cmd_is_write_o  = 1'b0;
        cmd_split_req_o = SPLIT_NONE;
        cmd_len_o       = '0;
        cmd_addr_o      = '0;

        case (state_q)
            IDLE: begin
                if (w_grant_r) begin
                    ar_ready_o   = 1'b1;
                    addr_d       = ar_addr_i;
                    len_d        = ar_len_i;
                    is_write_d   = 1'b0;
                    last_grant_d = GRANT_READ;
                    state_d      = ISSUE_A;
                end else if (w_grant_w) begin
                    aw_ready_o   = 1'b1;
                    addr_d       = aw_addr_i;
                    len_d        = aw_len_i;
                    is_write_d   = 1'b1;
                    last_grant_d = GRANT_WRITE;
                    state_d      = ISSUE_A;
                end
            end

            ISSUE_A: begin
                // Registered credit is used, so a W last in this same cycle
                // only lets the write go out on the following cycle.
                cmd_valid_o     = !is_write_q || (credit_q != '0);
                cmd_is_write_o  = is_write_q;
                cmd_split_req_o = w_split ? SPLIT_FIRST : SPLIT_NONE;
                cmd_len_o       = w_first_len;
                cmd_addr_o      = w_first_addr;
                if (cmd_valid_o && cmd_ready_i) begin
                    state_d = w_split ? ISSUE_B : IDLE;
                end
            end

            ISSUE_B: begin
                cmd_valid_o     = 1'b1;
                cmd_is_write_o  = is_write_q;
                cmd_split_req_o = SPLIT_SECOND;
                cmd_len_o       = w_second_len;
                cmd_addr_o      = w_second_addr;
                if (cmd_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mask credit: completed W bursts add, issued write commands subtract.
    always_comb begin
        credit_d = credit_q;
        if (w_last_hs_i && !w_credit_take) begin
            if (credit_q != CreditMax) begin
                credit_d = credit_q + 1'b1;
            end
        end else if (!w_last_hs_i && w_credit_take) begin
            credit_d = credit_q - 1'b1;
        end
    end

    // Credit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    // More completed W bursts than mask FIFO entries means upstream broke
    // the flow-control contract.
    a_credit_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(w_last_hs_i && !w_credit_take && (credit_q == CreditMax))
    );

`ifdef RPC_CMD_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count cycles a captured write waits in ISSUE_A for a mask; saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ISSUE_A) && is_write_q && (credit_q == '0)
                     && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign wr_stall_cnt_o = stall_cnt_q;
`else
    assign wr_stall_cnt_o = '0;
`endif

endmodule : rpc_cmd_scheduler

`default_nettype wire

// File: doc/rpc_cmd_scheduler.md
Name: rpc_cmd_scheduler

Overview:
- Accepts read (AR) and write (AW) burst requests and arbitrates between them round-robin.
- Splits any burst that crosses a DRAM page into two commands and issues them to the RPC command path using the split_req encoding 00/01/10.
- Issues a write command only when its write mask is already buffered. It counts completed W bursts, which equal mask FIFO pushes, so a mask pop always hits a non-empty FIFO.
- Sits between the AXI front end and the command splitter / write mask generator.

Parameters:
- AddrWidth, 32, byte address width.
- BufDepth, 4, mask FIFO depth minus 1. Must equal the mask generator's BufDepth.
- PageWords, 64, 32-byte words per DRAM page. Power of two, ≥64, so at most one split per burst.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- ar_valid_i  in  1  read request valid
- ar_ready_o  out  1  read request accepted
- ar_addr_i  in  AddrWidth  read byte address
- ar_len_i  in  6  read length in words, minus 1
- aw_valid_i  in  1  write request valid
- aw_ready_o  out  1  write request accepted
- aw_addr_i  in  AddrWidth  write byte address
- aw_len_i  in  6  write length in words, minus 1
- w_last_hs_i  in  1  W last-beat handshake (w_valid & w_ready & w_last)
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  command accepted
- cmd_is_write_o  out  1  1 = write
- cmd_split_req_o  out  2  00 unsplit, 01 first half, 10 second half
- cmd_len_o  out  6  command length in words, minus 1
- cmd_addr_o  out  AddrWidth  command byte address, 32-byte aligned
- busy_o  out  1  FSM not in IDLE
- wr_stall_cnt_o  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM = IDLE; mask credit = 0; last_grant = WRITE, so read wins the first tie.
- FSM states IDLE, ISSUE_A, ISSUE_B.
- IDLE, arbitration:
  - If exactly one of ar_valid_i/aw_valid_i is high, grant it.
  - If both are high, grant the side not equal to last_grant.
  - The granted side's ready is high combinationally in the same cycle; at most one ready per cycle.
  - Ready is never high outside IDLE.
- IDLE, request capture on grant:
  - Capture addr, len and type into the request register.
  - Compute word address wa = addr >> 5 and page offset off = wa mod PageWords.
  - split = (off + len ≥ PageWords), evaluated in 7+ bits, no wrap.
  - Update last_grant. Go to ISSUE_A.
- ISSUE_A:
  - cmd_addr_o = captured addr with bits [4:0] cleared.
  - Unsplit: split_req 00, len = len.
  - Split: split_req 01, len = PageWords - off - 1.
- ISSUE_B (split only):
  - split_req 10.
  - len = len - (PageWords - off).
  - addr = start of the next page: ((wa - off) + PageWords) << 5, truncated to AddrWidth (wraps at top of address space).
- Valid gating:
  - Reads: cmd_valid_o = 1 in ISSUE_A and ISSUE_B.
  - Writes in ISSUE_A: cmd_valid_o = (credit > 0).
  - Writes in ISSUE_B: no credit required.
  - Once asserted, valid and all cmd_* fields stay stable until handshake. Credit cannot drop while a command is pending, so this holds.
- Transitions:
  - ISSUE_A on handshake: to ISSUE_B if split, else to IDLE.
  - ISSUE_B on handshake: to IDLE.
  - No same-cycle re-grant on the return to IDLE; one bubble cycle minimum.
- Credit counter:
  - Width $clog2(BufDepth+2).
  - +1 on w_last_hs_i.
  - −1 on a write handshake with split_req 00 or 01.
  - Both in the same cycle: unchanged.
  - A W last arriving in the same cycle as a credit=0 ISSUE_A does not allow issue that cycle; the command issues next cycle.
  - Increment at credit = BufDepth+1 is an overflow: assertion fires, counter saturates.
- W bursts may complete before or after their AW is accepted. Ordering is guaranteed by AXI in-order W.
- Reset mid-operation: the pending command is dropped, credit is cleared and no handshake is reported. Upstream must reset together.

Optional Feature:
- Macro RPC_CMD_SCHED_PERF_EN.
- Defined: wr_stall_cnt_o is a 32-bit counter. It increments each cycle the FSM is in ISSUE_A with a write captured and credit = 0. It saturates at all-ones and resets to 0.
- Undefined: wr_stall_cnt_o is tied to 0 and no counter flops are built.

Decomposition:
- rpc_sched_pkg:
  - split_req_e enum (SPLIT_NONE=2'b00, SPLIT_FIRST=2'b01, SPLIT_SECOND=2'b10);
  - sched_state_e;
  - req_t struct (addr, len, is_write);
  - WordBytes = 32 constant.
- Sub-module rpc_page_split_calc: combinational; computes split, first/second len and second addr from req_t. Reused by the read path.
- Arbiter, FSM and credit counter stay in the top module.

Test Plan:
- Read, no split: ar addr 0x0000_0040, len 3 → one cmd: split 00, addr 0x40, len 3, is_write 0; ar_ready_o high for exactly 1 cycle.
- Read, page crossing: addr 0x0000_07E0 (off 63), len 3 → cmd1: split 01, len 0, addr 0x7E0; cmd2: split 10, len 2, addr 0x800.
- Write with credit gating: aw addr 0x100, len 0, no w_last → cmd_valid_o stays 0 for 10 cycles; pulse w_last_hs_i → cmd_valid_o high the next cycle; credit returns to 0 after handshake.
- Split write consumes one credit: two w_last pulses (credit 2), aw crossing page → split 01 then 10 issue back to back; credit ends at 1.
- Tie arbitration: ar and aw valid every cycle, credit pre-loaded → grants alternate R, W, R, W starting with R after reset; cmd_ready_i held low 5 cycles → cmd fields stable throughout.
- Perf (macro on): write pending with credit 0 for 7 cycles → wr_stall_cnt_o = 7; macro off → stays 0.
